alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end sharing one clocked ALU, one op per IDLE/EXEC/RESP pass.
// Optional macro ALU_LOCK_EN lets an accepted requester keep exclusive ownership of the ALU.
module alu_arbiter #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4:0]           req0_op,
  input  logic [DATA_SIZE-1:0] req0_a,
  input  logic [DATA_SIZE-1:0] req0_b,
  input  logic                 req0_lock,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4:0]           req1_op,
  input  logic [DATA_SIZE-1:0] req1_a,
  input  logic [DATA_SIZE-1:0] req1_b,
  input  logic                 req1_lock,
  output logic                 rsp0_valid,
  output logic [DATA_SIZE-1:0] rsp0_data,
  output logic                 rsp0_zero,
  output logic                 rsp0_carry,
  output logic                 rsp1_valid,
  output logic [DATA_SIZE-1:0] rsp1_data,
  output logic                 rsp1_zero,
  output logic                 rsp1_carry,
  output logic [4:0]           alu_select,
  output logic [DATA_SIZE-1:0] alu_a,
  output logic [DATA_SIZE-1:0] alu_b,
  output logic                 alu_op_enable,
  input  logic [DATA_SIZE-1:0] alu_out,
  input  logic                 alu_zero,
  input  logic                 alu_carry
);

  localparam logic [4:0] ALU_NOP = 5'h1F;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;

  logic [4:0]           op_q;
  logic [DATA_SIZE-1:0] a_q, b_q;
  logic                 idx_q;
  logic                 last_q;
  logic                 elig0, elig1;
  logic                 grant0, grant1;
  logic                 accept;

`ifdef ALU_LOCK_EN
  logic owned_q, owner_q;

  // An owner shuts the other requester out until it finishes with lock low.
  always_comb begin
    elig0 = req0_valid & ~(owned_q & owner_q);
    elig1 = req1_valid & ~(owned_q & ~owner_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owned_q <= 1'b0;
      owner_q <= 1'b0;
    end else if (accept) begin
      owned_q <= grant1 ? req1_lock : req0_lock;
      owner_q <= grant1;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = req0_lock ^ req1_lock;

  always_comb begin
    elig0 = req0_valid;
    elig1 = req1_valid;
  end
`endif

  // On a tie the requester that was not served last wins; gated by rst_n so reset clears ready at once.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (elig0 && elig1) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      idx_q  <= 1'b0;
      last_q <= 1'b1;
    end else if (accept) begin
      op_q   <= grant1 ? req1_op : req0_op;
      a_q    <= grant1 ? req1_a  : req0_a;
      b_q    <= grant1 ? req1_b  : req0_b;
      idx_q  <= grant1;
      last_q <= grant1;
    end
  end

  // Outside EXEC the ALU sees a zero pass-through so its carry flag survives between operations.
  always_comb begin
    state_next    = state;
    alu_select    = ALU_NOP;
    alu_a         = '0;
    alu_b         = '0;
    alu_op_enable = 1'b0;
    rsp0_valid    = 1'b0;
    rsp0_data     = '0;
    rsp0_zero     = 1'b0;
    rsp0_carry    = 1'b0;
    rsp1_valid    = 1'b0;
    rsp1_data     = '0;
    rsp1_zero     = 1'b0;
    rsp1_carry    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        alu_select = op_q;
        alu_a      = a_q;
        alu_b      = b_q;
        state_next = RESP;
      end
      RESP: begin
        alu_op_enable = 1'b1;
        if (idx_q) begin
          rsp1_valid = 1'b1;
          rsp1_data  = alu_out;
          rsp1_zero  = alu_zero;
          rsp1_carry = alu_carry;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = alu_out;
          rsp0_zero  = alu_zero;
          rsp0_carry = alu_carry;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives alu_arbiter with a behavioural ALU and checks it against a transaction-level model.
// Lock checks are included when ALU_LOCK_EN is defined.
module tb_alu_arbiter;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_ADC = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_lock;
  logic [4:0] req0_op;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_lock;
  logic [4:0] req1_op;
  logic [7:0] req1_a, req1_b;
  logic       rsp0_valid, rsp0_zero, rsp0_carry;
  logic [7:0] rsp0_data;
  logic       rsp1_valid, rsp1_zero, rsp1_carry;
  logic [7:0] rsp1_data;
  logic [4:0] alu_select;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       alu_op_enable, alu_zero, alu_carry;

  int tests_run    = 0;
  int tests_failed = 0;

  // Transaction-level reference state.
  int busy        = 0;
  int last_served = 1;
  bit owned_m     = 0;
  int owner_m     = 0;
  bit model_carry = 0;
  int pend_idx, pend_data;
  bit pend_zero, pend_carry;
  int cycle_no    = 0;
  int accept_cycle, last_rsp_cycle;
  logic [7:0] last_rsp_data;
  logic       last_rsp_zero, last_rsp_carry;
  int dut_grants[$];

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_lock(req1_lock),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_carry(rsp0_carry),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_carry(rsp1_carry),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_op_enable(alu_op_enable),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry)
  );

  // Stand-in for the shared ALU: registered result every clock, carry kept by non-arithmetic ops.
  logic [7:0] alu_out_r;
  logic       alu_carry_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r   <= '0;
      alu_carry_r <= 1'b0;
    end else begin
      case (alu_select)
        OP_ADD: {alu_carry_r, alu_out_r} <= {1'b0, alu_a} + {1'b0, alu_b};
        OP_ADC: {alu_carry_r, alu_out_r} <= {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_r};
        OP_SUB: {alu_carry_r, alu_out_r} <= {1'b0, alu_a} - {1'b0, alu_b};
        OP_AND: alu_out_r <= alu_a & alu_b;
        OP_OR:  alu_out_r <= alu_a | alu_b;
        OP_XOR: alu_out_r <= alu_a ^ alu_b;
        default: alu_out_r <= alu_a;
      endcase
    end
  end
  assign alu_out   = alu_out_r;
  assign alu_carry = alu_carry_r;
  assign alu_zero  = (alu_out_r == 8'd0);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic void ref_alu(input logic [4:0] op, input int a, input int b,
                                  output int data, output bit carry);
    int s;
    carry = model_carry;
    case (op)
      OP_ADD: begin s = a + b; data = s % 256; carry = (s > 255); end
      OP_ADC: begin s = a + b + int'(model_carry); data = s % 256; carry = (s > 255); end
      OP_SUB: begin s = a - b; data = (s + 256) % 256; carry = (s < 0); end
      OP_AND: data = a & b;
      OP_OR:  data = a | b;
      OP_XOR: data = a ^ b;
      default: data = a;
    endcase
    model_carry = carry;
  endfunction

  task automatic applyStimulus(input logic v0, input logic [4:0] op0, input logic [7:0] a0, input logic [7:0] b0, input logic l0,
                               input logic v1, input logic [4:0] op1, input logic [7:0] a1, input logic [7:0] b1, input logic l1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0; req0_lock = l0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1; req1_lock = l1;
  endtask

  // One clock: compare DUT against the model at negedge, then advance the model across the posedge.
  task automatic stepCycle();
    bit e0, e1, v0, v1, r0, r1, c;
    int gi, d;
    cycle_no++;
    @(negedge clk);
    e0 = 0; e1 = 0;
    if (rst_n && busy == 0) begin
      v0 = req0_valid; v1 = req1_valid;
`ifdef ALU_LOCK_EN
      if (owned_m) begin
        if (owner_m == 0) v1 = 0;
        else              v0 = 0;
      end
`endif
      if (v0 && v1) begin
        if (last_served == 1) e0 = 1;
        else                  e1 = 1;
      end else begin
        e0 = v0; e1 = v1;
      end
    end
    checkOutput("ready0", req0_ready, e0);
    checkOutput("ready1", req1_ready, e1);
    r0 = rst_n && busy == 1 && pend_idx == 0;
    r1 = rst_n && busy == 1 && pend_idx == 1;
    checkOutput("rsp0_valid", rsp0_valid, r0);
    checkOutput("rsp1_valid", rsp1_valid, r1);
    checkOutput("rsp0_data",  rsp0_data,  r0 ? pend_data  : 0);
    checkOutput("rsp0_zero",  rsp0_zero,  r0 ? pend_zero  : 0);
    checkOutput("rsp0_carry", rsp0_carry, r0 ? pend_carry : 0);
    checkOutput("rsp1_data",  rsp1_data,  r1 ? pend_data  : 0);
    checkOutput("rsp1_zero",  rsp1_zero,  r1 ? pend_zero  : 0);
    checkOutput("rsp1_carry", rsp1_carry, r1 ? pend_carry : 0);
    checkOutput("alu_op_enable", alu_op_enable, r0 | r1);
    if (rsp0_valid) begin
      last_rsp_data = rsp0_data; last_rsp_zero = rsp0_zero; last_rsp_carry = rsp0_carry; last_rsp_cycle = cycle_no;
    end
    if (rsp1_valid) begin
      last_rsp_data = rsp1_data; last_rsp_zero = rsp1_zero; last_rsp_carry = rsp1_carry; last_rsp_cycle = cycle_no;
    end
    if (req0_ready && req0_valid) dut_grants.push_back(0);
    if (req1_ready && req1_valid) dut_grants.push_back(1);
    if (e0 || e1) begin
      gi = e1 ? 1 : 0;
      if (gi == 1) ref_alu(req1_op, int'(req1_a), int'(req1_b), d, c);
      else         ref_alu(req0_op, int'(req0_a), int'(req0_b), d, c);
      pend_idx = gi; pend_data = d; pend_carry = c; pend_zero = (d == 0);
      last_served = gi;
      owned_m = (gi == 1) ? req1_lock : req0_lock;
      owner_m = gi;
      busy = 2;
      accept_cycle = cycle_no;
    end else if (busy > 0) begin
      busy--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_ready1", req1_ready, 0);
    checkOutput("rst_rsp0_valid", rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", rsp1_valid, 0);
    checkOutput("rst_rsp0_data", rsp0_data, 0);
    checkOutput("rst_alu_select", alu_select, 5'h1F);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_op_enable", alu_op_enable, 0);
    busy = 0; last_served = 1; owned_m = 0; owner_m = 0; model_carry = 0;
  endtask

  task automatic idleSteps(input int n);
    applyStimulus(0, OP_ADD, 0, 0, 0, 0, OP_ADD, 0, 0, 0);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    applyStimulus(0, OP_ADD, 0, 0, 0, 0, OP_ADD, 0, 0, 0);
    doReset();
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    idleSteps(1);

    // Both requesters hold ADD 1+1: grants alternate starting with req0.
    dut_grants.delete();
    applyStimulus(1, OP_ADD, 8'd1, 8'd1, 0, 1, OP_ADD, 8'd1, 8'd1, 0);
    for (int i = 0; i < 12; i++) stepCycle();
    checkOutput("alt_count", dut_grants.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("alt_grant", (dut_grants.size() > i) ? dut_grants[i] : 9, i % 2);
    checkOutput("alt_result", last_rsp_data, 8'd2);
    idleSteps(1);

    // Single req0 ADD F0+20.
    applyStimulus(1, OP_ADD, 8'hF0, 8'h20, 0, 0, OP_ADD, 0, 0, 0);
    stepCycle();
    idleSteps(2);
    checkOutput("add_latency", last_rsp_cycle, accept_cycle + 2);
    checkOutput("add_data", last_rsp_data, 8'h10);
    checkOutput("add_carry", last_rsp_carry, 1);
    checkOutput("add_zero", last_rsp_zero, 0);
    idleSteps(1);

    // SUB 5-5 then XOR AA^55.
    applyStimulus(1, OP_SUB, 8'd5, 8'd5, 0, 0, OP_ADD, 0, 0, 0);
    stepCycle();
    idleSteps(2);
    checkOutput("sub_data", last_rsp_data, 8'h00);
    checkOutput("sub_zero", last_rsp_zero, 1);
    checkOutput("sub_carry", last_rsp_carry, 0);
    applyStimulus(1, OP_XOR, 8'hAA, 8'h55, 0, 0, OP_ADD, 0, 0, 0);
    stepCycle();
    idleSteps(2);
    checkOutput("xor_data", last_rsp_data, 8'hFF);
    checkOutput("xor_zero", last_rsp_zero, 0);
    idleSteps(1);

    // Random traffic; inputs change every cycle, including while an op is in flight.
    for (int i = 0; i < 60; i++) begin
      applyStimulus($urandom_range(0, 1), 5'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1), 5'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      stepCycle();
    end
    idleSteps(3);

    // Reset during EXEC aborts the op; afterwards req0 wins a tie.
    applyStimulus(1, OP_ADD, 8'd3, 8'd4, 0, 0, OP_ADD, 0, 0, 0);
    stepCycle();
    doReset();
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    idleSteps(3);
    dut_grants.delete();
    applyStimulus(1, OP_ADD, 8'd1, 8'd2, 0, 1, OP_ADD, 8'd3, 8'd4, 0);
    stepCycle();
    checkOutput("post_rst_grant", (dut_grants.size() > 0) ? dut_grants[0] : 9, 0);
    idleSteps(3);

`ifdef ALU_LOCK_EN
    // req0 locks with ADD FF+01, drops valid, then finishes with ADC 0+0; req1 waits throughout.
    doReset();
    stepCycle();
    rst_n = 1'b1;
    idleSteps(1);
    applyStimulus(1, OP_ADD, 8'hFF, 8'h01, 1, 1, OP_SUB, 8'd9, 8'd2, 0);
    stepCycle();
    applyStimulus(0, OP_ADD, 0, 0, 0, 1, OP_SUB, 8'd9, 8'd2, 0);
    stepCycle();
    stepCycle();
    checkOutput("lock_first_data", last_rsp_data, 8'h00);
    checkOutput("lock_first_carry", last_rsp_carry, 1);
    stepCycle();
    stepCycle();
    applyStimulus(1, OP_ADC, 8'h00, 8'h00, 0, 1, OP_SUB, 8'd9, 8'd2, 0);
    stepCycle();
    applyStimulus(0, OP_ADD, 0, 0, 0, 1, OP_SUB, 8'd9, 8'd2, 0);
    stepCycle();
    stepCycle();
    checkOutput("lock_second_data", last_rsp_data, 8'h01);
    checkOutput("lock_second_carry", last_rsp_carry, 0);
    #3;
    checkOutput("lock_req1_ready", req1_ready, 1);
    stepCycle();
    idleSteps(3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
